// File: rtl/mem_burst_master.sv
// mem_burst_master: burst initiator for a synchronous single-port memory.
// Takes read/write burst commands over a valid/ready port and issues one
// memory access per cycle. Write beats arrive on their own stream. Read data
// comes back through a 2-entry response FIFO that honours rsp_ready.
// Optional build macro MEM_ADDR_CHECK_EN: each issued address is compared
// with the memory's registered address echo (mem_Ao). A mismatch raises a
// sticky err. Without the macro, err is tied low.
// AW/DW default to 16/32, standing in for the project-wide `ADDR/`WORD widths.
module mem_burst_master #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [DW-1:0]    wd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_last,
  output logic [AW-1:0]    mem_A,
  output logic             mem_W,
  output logic [DW-1:0]    mem_D,
  input  logic [DW-1:0]    mem_Q,
  input  logic [AW-1:0]    mem_Ao,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RD, DRAIN, WR} state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [LEN_W-1:0] beat_reg, beat_next;
  logic             inflight_reg, inflight_next;
  logic             inflight_last_reg, inflight_last_next;

  logic [DW-1:0]    fifo_data_reg [2];
  logic             fifo_last_reg [2];
  logic             wr_ptr_reg, rd_ptr_reg;
  logic [1:0]       count_reg;

  logic             push, pop, rd_room, issue_rd, wr_beat;
  logic [2:0]       occupancy;

  // The read issued last cycle lands in the FIFO now. The head leaves on a consumer handshake.
  assign push      = inflight_reg;
  assign pop       = (count_reg != 2'd0) && rsp_ready;
  // Issue only if the beat cannot overflow the FIFO once it returns next cycle.
  assign occupancy = {1'b0, count_reg} + {2'b0, inflight_reg};
  assign rd_room   = occupancy <= (3'd1 + {2'b0, pop});

  // The address stays on the last issued word between bursts.
  assign mem_A     = addr_reg;
  assign rsp_valid = (count_reg != 2'd0);
  assign rsp_data  = fifo_data_reg[rd_ptr_reg];
  assign rsp_last  = rsp_valid & fifo_last_reg[rd_ptr_reg];
  assign busy      = (state_reg != IDLE) || (count_reg != 2'd0);

  // Next-state, counters and memory-side strobes for the burst sequencer.
  always_comb begin
    state_next         = state_reg;
    addr_next          = addr_reg;
    beat_next          = beat_reg;
    inflight_next      = 1'b0;
    inflight_last_next = inflight_last_reg;
    req_ready          = 1'b0;
    wd_ready           = 1'b0;
    mem_W              = 1'b0;
    mem_D              = '0;
    issue_rd           = 1'b0;
    wr_beat            = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_next  = req_addr;
          beat_next  = req_len;
          state_next = req_we ? WR : RD;
        end
      end
      RD: begin
        if (rd_room) begin
          issue_rd           = 1'b1;
          inflight_next      = 1'b1;
          inflight_last_next = (beat_reg == '0);
          if (beat_reg == '0) begin
            state_next = DRAIN;
          end else begin
            addr_next = addr_reg + 1'b1;
            beat_next = beat_reg - 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!inflight_reg && (count_reg == 2'd0)) state_next = IDLE;
      end
      WR: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          wr_beat = 1'b1;
          mem_W   = 1'b1;
          mem_D   = wd_data;
          if (beat_reg == '0) begin
            state_next = IDLE;
          end else begin
            addr_next = addr_reg + 1'b1;
            beat_next = beat_reg - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, burst counters and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      beat_reg          <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      beat_reg          <= beat_next;
      inflight_reg      <= inflight_next;
      inflight_last_reg <= inflight_last_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // One storage slot per FIFO entry, written when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fifo_data_reg[gi] <= '0;
          fifo_last_reg[gi] <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_data_reg[gi] <= mem_Q;
          fifo_last_reg[gi] <= inflight_last_reg;
        end
      end
    end
  endgenerate

`ifdef MEM_ADDR_CHECK_EN
  logic          chk_valid_reg;
  logic [AW-1:0] chk_addr_reg;
  logic          err_reg;

  // Remember each issued address, then check the memory's echo one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid_reg <= 1'b0;
      chk_addr_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      chk_valid_reg <= issue_rd | wr_beat;
      chk_addr_reg  <= addr_reg;
      if (chk_valid_reg && (mem_Ao != chk_addr_reg)) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  logic unused_check;
  assign unused_check = ^{mem_Ao, issue_rd, wr_beat};
  assign err = 1'b0;
`endif

endmodule
